// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
// Shared constants and types for the packed DSP MAC accumulator read side.
//   ACC_W_88 / ACC_W_18 : lane widths in 8x8 and 1x8 modes
//   LANES_88 / LANES_18 : lanes per packed word in each mode
//   MODE_88 / MODE_18   : encodings of the per-word mode bit
//   state_e             : drain FSM state encoding
// ----------------------------------------------------------------------------
package mac_pkg;

    localparam int ACC_W_88 = 24;
    localparam int ACC_W_18 = 16;
    localparam int LANES_88 = 2;
    localparam int LANES_18 = 4;

    localparam logic MODE_88 = 1'b0;
    localparam logic MODE_18 = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/mac_lane_select.sv
// ----------------------------------------------------------------------------
// mac_lane_select
// Combinational lane mux: picks one signed lane out of a packed accumulator
// word and sign-extends it to OUT_W. When MAC_DRAIN_SAT_EN is defined the
// lane is clamped to the signed SAT_W range before extension.
// Ports:
//   acc_i  [PACK_W-1:0] packed accumulator word
//   mode_i              0 = 8x8 (2 x ACC_W_88), 1 = 1x8 (4 x ACC_W_18)
//   lane_i [1:0]        lane index to extract
//   data_o [OUT_W-1:0]  sign-extended (optionally clamped) lane value
// ----------------------------------------------------------------------------
module mac_lane_select #(
    parameter int ACC_W_88 = 24,
    parameter int ACC_W_18 = 16,
    parameter int PACK_W   = 64,
    parameter int OUT_W    = 24,
    parameter int SAT_W    = 8
) (
    input  logic [PACK_W-1:0] acc_i,
    input  logic              mode_i,
    input  logic [1:0]        lane_i,
    output logic [OUT_W-1:0]  data_o
);
    import mac_pkg::*;

    logic [ACC_W_88-1:0]        lane88;
    logic [ACC_W_18-1:0]        lane18;
    logic signed [ACC_W_88-1:0] selected;
    logic signed [ACC_W_88-1:0] clamped;

    // Both candidate slices are extracted every cycle; the narrow 1x8 lane is
    // first widened to the 8x8 lane width so a single clamp/extend path serves
    // both modes. Upper bits beyond 2*ACC_W_88 are never looked at in mode 0.
    always_comb begin
        lane88 = '0;
        lane18 = '0;
        for (int k = 0; k < LANES_88; k++) begin
            if (lane_i == 2'(k)) begin
                lane88 = acc_i[k*ACC_W_88 +: ACC_W_88];
            end
        end
        for (int k = 0; k < LANES_18; k++) begin
            if (lane_i == 2'(k)) begin
                lane18 = acc_i[k*ACC_W_18 +: ACC_W_18];
            end
        end
        selected = (mode_i == MODE_18) ? ACC_W_88'($signed(lane18)) : lane88;
    end

`ifdef MAC_DRAIN_SAT_EN
    localparam logic signed [ACC_W_88-1:0] SAT_MAX = ACC_W_88'((1 << (SAT_W - 1)) - 1);
    localparam logic signed [ACC_W_88-1:0] SAT_MIN = ACC_W_88'(-(1 << (SAT_W - 1)));

    // Single signed compare stage against the SAT_W limits.
    always_comb begin
        clamped = selected;
        if (selected > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (selected < SAT_MIN) begin
            clamped = SAT_MIN;
        end
    end
`else
    logic [31:0] unusedSatW;
    assign unusedSatW = SAT_W;
    assign clamped    = selected;
`endif

    assign data_o = OUT_W'(clamped);

endmodule

// File: rtl/mac_acc_drain_unpacker.sv
// ----------------------------------------------------------------------------
// mac_acc_drain_unpacker
// Read side of the dual-mode packed DSP MAC accumulator. Accepts one packed
// word on a valid/ready handshake, then streams its signed lanes out one per
// consumed cycle (2 lanes in 8x8 mode, 4 lanes in 1x8 mode), sign-extended to
// OUT_W. Optional clamping to SAT_W is enabled by defining MAC_DRAIN_SAT_EN.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   input handshake for a packed word
//   in_mode               0 = 8x8, 1 = 1x8, captured with the word
//   in_acc [PACK_W-1:0]   packed accumulator word
//   in_last               tile-end tag, reported on the word's final lane
//   out_valid / out_ready output lane handshake
//   out_data [OUT_W-1:0]  signed lane value
//   out_lane [1:0]        index of the lane on out_data
//   out_last              final lane of a word tagged in_last
// ----------------------------------------------------------------------------
module mac_acc_drain_unpacker #(
    parameter int ACC_W_88 = 24,
    parameter int ACC_W_18 = 16,
    parameter int PACK_W   = 64,
    parameter int OUT_W    = 24,
    parameter int SAT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [PACK_W-1:0] in_acc,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [1:0]        out_lane,
    output logic              out_last
);
    import mac_pkg::*;

    // Legacy-style state constants tied to the shared enum encoding.
    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_DRAIN = DRAIN;

    logic [0:0]        state_q, state_d;
    logic [PACK_W-1:0] acc_q,   acc_d;
    logic              mode_q,  mode_d;
    logic              last_q,  last_d;
    logic [1:0]        lane_q,  lane_d;
    logic [OUT_W-1:0]  data_q,  data_d;
    logic [OUT_W-1:0]  selData;

    logic lastLane;
    logic consume;
    logic accept;
    logic load;
    logic advance;

    assign lastLane = (mode_q == MODE_18) ? (lane_q == 2'(LANES_18 - 1))
                                          : (lane_q == 2'(LANES_88 - 1));
    assign consume  = (state_q == S_DRAIN) && out_ready;

    // Ready also opens while the final lane is being consumed, so a waiting
    // word is captured in the same cycle and the output stream has no bubble.
    assign in_ready = (state_q == S_IDLE) || (consume && lastLane);
    assign accept   = in_valid && in_ready;

    // Control: decide whether this cycle loads a fresh word, steps to the
    // next lane, or falls back to IDLE after the last lane drains.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        last_d  = last_q;
        lane_d  = lane_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            S_DRAIN: begin
                if (consume) begin
                    if (lastLane) begin
                        if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            acc_d   = in_acc;
            mode_d  = in_mode;
            last_d  = in_last;
            lane_d  = 2'd0;
            state_d = S_DRAIN;
        end
        if (advance) begin
            lane_d = lane_q + 2'd1;
        end
    end

    // The lane mux looks at next-state values so the selected lane lands in
    // the output register together with the word/lane that produced it.
    mac_lane_select #(
        .ACC_W_88 (ACC_W_88),
        .ACC_W_18 (ACC_W_18),
        .PACK_W   (PACK_W),
        .OUT_W    (OUT_W),
        .SAT_W    (SAT_W)
    ) u_laneSelect (
        .acc_i  (acc_d),
        .mode_i (mode_d),
        .lane_i (lane_d),
        .data_o (selData)
    );

    // Output data only changes when a new lane becomes current; during a stall
    // it holds, and after the drain finishes it simply keeps its last value.
    always_comb begin
        data_d = data_q;
        if (load || advance) begin
            data_d = selData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mode_q  <= MODE_88;
            last_q  <= 1'b0;
            lane_q  <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = data_q;
    assign out_lane  = lane_q;
    assign out_last  = (state_q == S_DRAIN) && last_q && lastLane;

endmodule

// File: tb/tb_mac_acc_drain_unpacker.sv
// ----------------------------------------------------------------------------
// tb_mac_acc_drain_unpacker
// Scoreboard bench for mac_acc_drain_unpacker: directed words push their
// hand-computed lanes into a queue, and a monitor pops and compares every
// lane the DUT hands over. Expected clamp values follow MAC_DRAIN_SAT_EN.
// ----------------------------------------------------------------------------
module tb_mac_acc_drain_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    typedef struct packed {
        logic [23:0] data;
        logic [1:0]  lane;
        logic        last;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    mac_acc_drain_unpacker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [23:0] data, input logic [1:0] lane, input logic last);
        exp_t e;
        e.data = data;
        e.lane = lane;
        e.last = last;
        expQ.push_back(e);
    endtask

    // Present a word and hold it until the DUT takes it (bounded wait).
    // Returns one cycle after acceptance, with in_valid still high.
    task automatic applyStimulus(input logic [63:0] acc, input logic mode, input logic last);
        logic accepted;
        accepted = 1'b0;
        in_acc   = acc;
        in_mode  = mode;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !accepted; t++) begin
            #1;
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("wordAccepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic waitDrain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !out_valid) done = 1'b1;
        end
        checkOutput("drainDone", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed lane must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedLane: got lane %0d data 0x%0h, expected no lane", out_lane, out_data);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("laneData", {8'd0, out_data}, {8'd0, monExp.data});
                checkOutput("laneIndex", {30'd0, out_lane}, {30'd0, monExp.lane});
                checkOutput("laneLast", {31'd0, out_last}, {31'd0, monExp.last});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] validBits;
        logic [7:0] readyBits;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_acc    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstOutData", {8'd0, out_data}, 32'd0);
        checkOutput("rstOutLane", {30'd0, out_lane}, 32'd0);
        checkOutput("rstOutLast", {31'd0, out_last}, 32'd0);
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Mode 0: +5 and -2, tagged last
        $display("[TB] mode 0 word");
        pushExp(24'h000005, 2'd0, 1'b0);
        pushExp(24'hFFFFFE, 2'd1, 1'b1);
        applyStimulus(64'h0000_FFFF_FE00_0005, 1'b0, 1'b1);
        in_valid = 1'b0;
        waitDrain();
        checkOutput("idleReady", {31'd0, in_ready}, 32'd1);

        // Mode 1: 1, -1, 32767, -32768
        $display("[TB] mode 1 word");
`ifdef MAC_DRAIN_SAT_EN
        pushExp(24'h000001, 2'd0, 1'b0);
        pushExp(24'hFFFFFF, 2'd1, 1'b0);
        pushExp(24'h00007F, 2'd2, 1'b0);
        pushExp(24'hFFFF80, 2'd3, 1'b1);
`else
        pushExp(24'h000001, 2'd0, 1'b0);
        pushExp(24'hFFFFFF, 2'd1, 1'b0);
        pushExp(24'h007FFF, 2'd2, 1'b0);
        pushExp(24'hFF8000, 2'd3, 1'b1);
`endif
        applyStimulus(64'h8000_7FFF_FFFF_0001, 1'b1, 1'b1);
        in_valid = 1'b0;
        waitDrain();

        // Back-to-back mode 1 words
        $display("[TB] back-to-back words");
        pushExp(24'h000001, 2'd0, 1'b0);
        pushExp(24'h000002, 2'd1, 1'b0);
        pushExp(24'h000003, 2'd2, 1'b0);
        pushExp(24'h000004, 2'd3, 1'b0);
        pushExp(24'hFFFFFF, 2'd0, 1'b0);
        pushExp(24'hFFFFFE, 2'd1, 1'b0);
        pushExp(24'hFFFFFD, 2'd2, 1'b0);
        pushExp(24'hFFFFFC, 2'd3, 1'b1);
        applyStimulus(64'h0004_0003_0002_0001, 1'b1, 1'b0);
        fork
            begin
                applyStimulus(64'hFFFC_FFFD_FFFE_FFFF, 1'b1, 1'b1);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    validBits[i] = out_valid;
                    readyBits[i] = in_ready;
                end
            end
        join
        checkOutput("b2bNoGap", {24'd0, validBits}, 32'h0000_00FF);
        checkOutput("b2bReadyPulse", {24'd0, readyBits}, 32'h0000_0088);
        waitDrain();

        // Backpressure on a mode 0 word: ready 1,0,0,1
        $display("[TB] backpressure");
`ifdef MAC_DRAIN_SAT_EN
        pushExp(24'h00007F, 2'd0, 1'b0);
        pushExp(24'h00007F, 2'd1, 1'b0);
`else
        pushExp(24'h654321, 2'd0, 1'b0);
        pushExp(24'h123456, 2'd1, 1'b0);
`endif
        applyStimulus(64'h0000_1234_5665_4321, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bpReadyLow0", {31'd0, in_ready}, 32'd0);
        for (int s = 0; s < 2; s++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
`ifdef MAC_DRAIN_SAT_EN
            checkOutput("bpStallData", {8'd0, out_data}, 32'h0000_007F);
`else
            checkOutput("bpStallData", {8'd0, out_data}, 32'h0012_3456);
`endif
            checkOutput("bpStallLane", {30'd0, out_lane}, 32'd1);
            checkOutput("bpStallValid", {31'd0, out_valid}, 32'd1);
            checkOutput("bpReadyLow", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain();

        // Reset in the middle of a mode 1 drain
        $display("[TB] reset mid-drain");
        pushExp(24'h000011, 2'd0, 1'b0);
        pushExp(24'h000022, 2'd1, 1'b0);
        applyStimulus(64'h0044_0033_0022_0011, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstMidValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstMidReady", {31'd0, in_ready}, 32'd1);
        checkOutput("rstMidQueue", expQ.size(), 32'd0);
        @(posedge clk);
        #1;
        pushExp(24'hFFFFF6, 2'd0, 1'b0);
        pushExp(24'h00000A, 2'd1, 1'b0);
        applyStimulus(64'h0000_0000_0AFF_FFF6, 1'b0, 1'b0);
        in_valid = 1'b0;
        waitDrain();

        // Lanes 300, -300, 5, -5
        $display("[TB] clamp-range word");
`ifdef MAC_DRAIN_SAT_EN
        pushExp(24'h00007F, 2'd0, 1'b0);
        pushExp(24'hFFFF80, 2'd1, 1'b0);
`else
        pushExp(24'h00012C, 2'd0, 1'b0);
        pushExp(24'hFFFED4, 2'd1, 1'b0);
`endif
        pushExp(24'h000005, 2'd2, 1'b0);
        pushExp(24'hFFFFFB, 2'd3, 1'b0);
        applyStimulus(64'hFFFB_0005_FED4_012C, 1'b1, 1'b0);
        in_valid = 1'b0;
        waitDrain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mac_acc_drain_unpacker.md
Name: mac_acc_drain_unpacker

Overview:
- Read side of the dual-mode packed DSP MAC accumulator.
- Captures one packed accumulator word on a valid/ready handshake and splits it into signed lanes:
  - 2 x 24-bit lanes in 8x8 mode.
  - 4 x 16-bit lanes in 1x8 mode.
- Sign-extends each lane to a common width and streams the lanes out one per cycle.
- Sits between the PE accumulator array and the post-processing/write-back path.

Parameters:
- ACC_W_88, 24, lane width in mode 0 (8x8: 2 lanes).
- ACC_W_18, 16, lane width in mode 1 (1x8: 4 lanes).
- PACK_W, 64, packed input width; must be >= max(2*ACC_W_88, 4*ACC_W_18).
- OUT_W, 24, output lane width; must be >= ACC_W_88.
- SAT_W, 8, saturation width, used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  packed word available.
- in_ready  out  1  block can accept a word this cycle.
- in_mode  in  1  0 = 8x8 (2 lanes), 1 = 1x8 (4 lanes); sampled with the word.
- in_acc  in  PACK_W  packed accumulator word.
- in_last  in  1  word is the last of a tile; forwarded on the final lane.
- out_valid  out  1  lane data valid.
- out_ready  in  1  downstream accepts a lane.
- out_data  out  OUT_W  signed lane value.
- out_lane  out  2  lane index of out_data.
- out_last  out  1  final lane of a word tagged in_last.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: out_valid=0, out_data=0, out_lane=0, out_last=0, in_ready=1.
  - State: FSM=IDLE, lane counter=0, capture register=0.
  - Reset asserted mid-drain discards the held word; no lane is emitted after reset.
- Handshake rules:
  - A word is accepted when in_valid && in_ready.
  - A lane is consumed when out_valid && out_ready.
  - out_data, out_lane and out_last are held stable while out_valid && !out_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept, register in_acc, in_mode and in_last, set lane=0, go to DRAIN.
  - DRAIN: out_valid=1 and out_data is the lane selected by the counter.
    - On a consumed lane that is not the last lane: lane++.
    - On the consumed last lane (lane==1 in mode 0, lane==3 in mode 1): if in_valid in the same cycle, capture the new word and stay in DRAIN with lane=0; otherwise go to IDLE.
  - in_ready = (state==IDLE) || (state==DRAIN && out_ready && last lane). This gives back-to-back words with zero bubble.
- Lane extraction (lane k):
  - Mode 0: acc[k*24 +: 24], sign-extended to OUT_W. Bits above 47 are ignored.
  - Mode 1: acc[k*16 +: 16], sign-extended from bit 15 to OUT_W.
- out_last = captured in_last && last lane; 0 on all other lanes.
- Latency:
  - First lane is visible the cycle after the word is accepted (registered output).
  - A word drains in 2 (mode 0) or 4 (mode 1) consumed cycles.
- in_mode is registered per word, so a mode change between words is legal and takes effect on the new word only.

Optional Feature:
- Macro: MAC_DRAIN_SAT_EN.
- Defined: each lane is clamped to signed SAT_W range [-2^(SAT_W-1), 2^(SAT_W-1)-1] before sign-extension to OUT_W. A clamp is a single comparison stage inside the same output register, so latency is unchanged.
- Undefined: no clamp, full sign-extended lane passes through.

Decomposition:
- Shared package (mac_pkg) holds:
  - Constants ACC_W_88, ACC_W_18, LANES_88=2, LANES_18=4.
  - MODE_88=1'b0, MODE_18=1'b1.
  - Typedef for the FSM state enum {IDLE, DRAIN}.
- One sub-module: mac_lane_select, a combinational lane mux plus sign-extend (plus clamp when enabled), instantiated once.

Test Plan:
- Mode 0, in_acc=0x0000_FFFF_FE_000005, out_ready=1:
  - out lane0 = +5 (0x000005), lane1 = 0xFFFFFE = -2.
  - Returns to IDLE.
- Mode 1, in_acc=0x8000_7FFF_FFFF_0001:
  - Lanes 0..3 = 1, -1, 32767, -32768, each sign-extended to 24 bits.
  - out_last only on lane 3 when in_last=1.
- Back-to-back: two mode-1 words with in_valid held high and out_ready=1:
  - 8 consecutive valid lanes, no gap.
  - in_ready pulses exactly on cycles 4 and 8 of output.
- Backpressure: out_ready toggles 1,0,0,1 during a mode-0 drain:
  - out_data stable across the stalls.
  - Lane order 0,1 preserved; in_ready low throughout.
- Reset after lane 1 of a mode-1 word:
  - Next cycle out_valid=0, in_ready=1.
  - Next word starts at lane 0.
- MAC_DRAIN_SAT_EN defined, mode 1 lanes 300, -300, 5, -5 -> outputs 127, -128, 5, -5. Undefined -> 300, -300, 5, -5.
